code_capture_fifo: RTL and testbench

CODE_CAPTURE_FIFO -- requirements
Module: code_capture_fifo

---
 rtl/code_capture_fifo.sv | 102 ++++++++++
 tb/tb_code_capture_fifo.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/code_capture_fifo.sv
// Captures new codes from an upstream 4-to-2 priority encoder into a small FIFO.
// An event is a VAL rising edge or a code change while VAL stays high.
module code_capture_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     S1,
  input  logic                     S2,
  input  logic                     VAL,
  output logic [1:0]               out_code,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  input  logic                     clr_ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  // Handshake: the head entry transfers on a rising edge where out_valid and
  // out_ready are both high; out_code is held stable while out_valid=1 and
  // out_ready=0. There is no fall-through: a push becomes visible after its edge.

  logic [1:0]    code_in;
  logic          prev_val_q, prev_val_d;
  logic [1:0]    prev_code_q, prev_code_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic [1:0]    mem_q [DEPTH];

  logic          evt;
  logic          full;
  logic          empty;
  logic          pop;
  logic          push;
  logic          drop;

  assign code_in = {S2, S1};
  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign evt     = VAL && (!prev_val_q || (code_in != prev_code_q));
  assign pop     = !empty && out_ready;
  // A full FIFO still accepts an event when the head leaves in the same cycle.
  assign push    = evt && (!full || pop);
  assign drop    = evt && full && !pop;

  always_comb begin
    prev_val_d  = VAL;
    prev_code_d = code_in;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q + CW'(push) - CW'(pop);
    overflow_d  = overflow_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    // A fresh drop wins over a clear arriving in the same cycle.
    if (drop) begin
      overflow_d = 1'b1;
    end else if (clr_ovf) begin
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_val_q  <= 1'b0;
      prev_code_q <= 2'b00;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
    end else begin
      prev_val_q  <= prev_val_d;
      prev_code_q <= prev_code_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
    end
  end

  // Storage is not reset; the empty check below keeps stale entries hidden.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem_q[wr_ptr_q] <= code_in;
    end
  end

  assign out_valid = !empty;
  assign out_code  = empty ? 2'b00 : mem_q[rd_ptr_q];
  assign count     = count_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_code_capture_fifo.sv
// Bench for code_capture_fifo: directed vector table, wrap sequence and random
// traffic, all checked against a queue-based scoreboard.
module tb_code_capture_fifo;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst, S1, S2, VAL, out_ready, clr_ovf;
  logic [1:0] out_code;
  logic       out_valid, overflow;
  logic [2:0] count;

  int errors = 0;
  int checks = 0;

  code_capture_fifo #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .S1(S1), .S2(S2), .VAL(VAL),
    .out_code(out_code), .out_valid(out_valid), .out_ready(out_ready),
    .count(count), .overflow(overflow), .clr_ovf(clr_ovf)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard ----------------
  logic [1:0] exp_q[$];
  logic       m_pv = 1'b0;
  logic [1:0] m_pc = 2'b00;
  logic       m_ovf = 1'b0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- driver ----------------
  // Drives one cycle of inputs, advances the model and compares all outputs.
  task automatic apply(input logic r, input logic v, input logic [1:0] c,
                       input logic rdy, input logic clr);
    logic       pop_m, ev_m, full_m;
    logic [1:0] head;
    @(negedge clk);
    rst = r; VAL = v; S2 = c[1]; S1 = c[0]; out_ready = rdy; clr_ovf = clr;
    pop_m  = (exp_q.size() != 0) && rdy;
    ev_m   = v && (!m_pv || (c != m_pc));
    full_m = (exp_q.size() == DEPTH);
    if (!r && pop_m) begin
      head = exp_q[0];
      check("head_at_pop", 8'(out_code), 8'(head));
    end
    @(posedge clk);
    if (r) begin
      exp_q.delete();
      m_pv = 1'b0; m_pc = 2'b00; m_ovf = 1'b0;
    end else begin
      if (pop_m) void'(exp_q.pop_front());
      if (ev_m && (!full_m || pop_m)) exp_q.push_back(c);
      if (ev_m && full_m && !pop_m) m_ovf = 1'b1;
      else if (clr) m_ovf = 1'b0;
      m_pv = v; m_pc = c;
    end
    #1;
    check("sb_count", 8'(count), 8'(exp_q.size()));
    check("sb_valid", 8'(out_valid), 8'(exp_q.size() != 0));
    head = (exp_q.size() != 0) ? exp_q[0] : 2'b00;
    check("sb_code", 8'(out_code), 8'(head));
    check("sb_ovf", 8'(overflow), 8'(m_ovf));
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic       r, v;
    logic [1:0] c;
    logic       rdy, clr;
    logic [2:0] e_cnt;
    logic       e_vld;
    logic [1:0] e_code;
    logic       e_ovf;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic r, logic v, logic [1:0] c, logic rdy, logic clr,
                              logic [2:0] e_cnt, logic e_vld, logic [1:0] e_code, logic e_ovf);
    vec_t t;
    t.r = r; t.v = v; t.c = c; t.rdy = rdy; t.clr = clr;
    t.e_cnt = e_cnt; t.e_vld = e_vld; t.e_code = e_code; t.e_ovf = e_ovf;
    return t;
  endfunction

  initial begin
    rst = 1'b1; VAL = 1'b0; S1 = 1'b0; S2 = 1'b0; out_ready = 1'b0; clr_ovf = 1'b0;

    // reset, then held code 11 gives one event
    vecs.push_back(mk(1,0,2'b00,0,0, 3'd0,0,2'b00,0));
    for (int i = 0; i < 5; i++) vecs.push_back(mk(0,1,2'b11,0,0, 3'd1,1,2'b11,0));
    vecs.push_back(mk(1,0,2'b00,0,0, 3'd0,0,2'b00,0));
    // four codes in, four out in order, then empty with ready high
    vecs.push_back(mk(0,1,2'b01,0,0, 3'd1,1,2'b01,0));
    vecs.push_back(mk(0,1,2'b10,0,0, 3'd2,1,2'b01,0));
    vecs.push_back(mk(0,1,2'b11,0,0, 3'd3,1,2'b01,0));
    vecs.push_back(mk(0,1,2'b00,0,0, 3'd4,1,2'b01,0));
    vecs.push_back(mk(0,0,2'b00,1,0, 3'd3,1,2'b10,0));
    vecs.push_back(mk(0,0,2'b00,1,0, 3'd2,1,2'b11,0));
    vecs.push_back(mk(0,0,2'b00,1,0, 3'd1,1,2'b00,0));
    vecs.push_back(mk(0,0,2'b00,1,0, 3'd0,0,2'b00,0));
    vecs.push_back(mk(0,0,2'b00,1,0, 3'd0,0,2'b00,0));
    // overflow on full, set wins over clear, then clear
    vecs.push_back(mk(0,1,2'b01,0,0, 3'd1,1,2'b01,0));
    vecs.push_back(mk(0,1,2'b10,0,0, 3'd2,1,2'b01,0));
    vecs.push_back(mk(0,1,2'b11,0,0, 3'd3,1,2'b01,0));
    vecs.push_back(mk(0,1,2'b00,0,0, 3'd4,1,2'b01,0));
    vecs.push_back(mk(0,1,2'b01,0,0, 3'd4,1,2'b01,1));
    vecs.push_back(mk(0,1,2'b10,0,1, 3'd4,1,2'b01,1));
    vecs.push_back(mk(0,0,2'b00,0,1, 3'd4,1,2'b01,0));
    // full with simultaneous event and pop; new code drains 4th
    vecs.push_back(mk(0,1,2'b11,1,0, 3'd4,1,2'b10,0));
    vecs.push_back(mk(0,0,2'b00,1,0, 3'd3,1,2'b11,0));
    vecs.push_back(mk(0,0,2'b00,1,0, 3'd2,1,2'b00,0));
    vecs.push_back(mk(0,0,2'b00,1,0, 3'd1,1,2'b11,0));
    vecs.push_back(mk(0,0,2'b00,1,0, 3'd0,0,2'b00,0));
    // count=3 with overflow, then reset clears all; VAL held through release
    vecs.push_back(mk(0,1,2'b01,0,0, 3'd1,1,2'b01,0));
    vecs.push_back(mk(0,1,2'b10,0,0, 3'd2,1,2'b01,0));
    vecs.push_back(mk(0,1,2'b11,0,0, 3'd3,1,2'b01,0));
    vecs.push_back(mk(0,1,2'b00,0,0, 3'd4,1,2'b01,0));
    vecs.push_back(mk(0,1,2'b10,0,0, 3'd4,1,2'b01,1));
    vecs.push_back(mk(0,0,2'b00,1,0, 3'd3,1,2'b10,1));
    vecs.push_back(mk(1,1,2'b11,1,1, 3'd0,0,2'b00,0));
    vecs.push_back(mk(0,1,2'b11,0,0, 3'd1,1,2'b11,0));
    vecs.push_back(mk(0,1,2'b11,0,0, 3'd1,1,2'b11,0));
    // VAL toggling with a constant code gives two events
    vecs.push_back(mk(1,0,2'b00,0,0, 3'd0,0,2'b00,0));
    vecs.push_back(mk(0,1,2'b10,0,0, 3'd1,1,2'b10,0));
    vecs.push_back(mk(0,0,2'b10,0,0, 3'd1,1,2'b10,0));
    vecs.push_back(mk(0,1,2'b10,0,0, 3'd2,1,2'b10,0));

    apply(1, 0, 2'b00, 0, 0);
    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i].r, vecs[i].v, vecs[i].c, vecs[i].rdy, vecs[i].clr);
      check($sformatf("vec%0d_count", i), 8'(count), 8'(vecs[i].e_cnt));
      check($sformatf("vec%0d_valid", i), 8'(out_valid), 8'(vecs[i].e_vld));
      check($sformatf("vec%0d_code", i), 8'(out_code), 8'(vecs[i].e_code));
      check($sformatf("vec%0d_ovf", i), 8'(overflow), 8'(vecs[i].e_ovf));
    end

    // streaming across pointer wrap: push and pop every cycle
    for (int i = 0; i < 10; i++) begin
      logic [1:0] c;
      c = 2'((i + 3) % 4);
      apply(0, 1, c, 1, 0);
      check($sformatf("wrap%0d_count", i), 8'(count), 8'd2);
    end
    for (int i = 0; i < 2; i++) apply(0, 0, 2'b00, 1, 0);
    check("wrap_drained", 8'(count), 8'd0);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      apply($urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0,
            2'($urandom_range(0, 3)), $urandom_range(0, 1) == 1,
            $urandom_range(0, 7) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
